// File: rtl/trig_in_pkg.sv
// Shared defaults and per-channel state record for the coax input front end.
package trig_in_pkg;

  localparam int NCH_DEF     = 16;
  localparam int MINW_W_DEF  = 4;
  localparam int HOLD_W_DEF  = 8;
  localparam int SCAL_W_DEF  = 24;
  localparam int GATE_W_DEF  = 26;
  localparam int STUCK_W_DEF = 16;

  typedef struct packed {
    logic [MINW_W_DEF-1:0]  wcnt;
    logic                   armed;
    logic [HOLD_W_DEF-1:0]  hcnt;
    logic [STUCK_W_DEF-1:0] stuck_cnt;
  } chan_state_t;

  // A programmed width of zero behaves as a single-sample requirement.
  function automatic logic [MINW_W_DEF-1:0] eff_width(input logic [MINW_W_DEF-1:0] min_width);
    eff_width = (min_width == '0) ? MINW_W_DEF'(1) : min_width;
  endfunction

endpackage

// File: rtl/coax_chan_filter.sv
// One coax channel: synchroniser, glitch-width qualifier, one-hit-per-pulse arming,
// per-channel holdoff and stuck-high detection.
module coax_chan_filter
  import trig_in_pkg::*;
#(
  parameter int STUCK_W = STUCK_W_DEF
) (
  input  logic                  clk_adc,
  input  logic                  nrst,
  input  logic                  coax_raw,
  input  logic                  enable,
  input  logic [MINW_W_DEF-1:0] min_width,
  input  logic [HOLD_W_DEF-1:0] holdoff,
  output logic                  hit,
  output logic                  level,
  output logic                  stuck
);

  localparam logic [STUCK_W_DEF-1:0] STUCK_MAX = STUCK_W_DEF'((64'd1 << STUCK_W) - 64'd1);

  logic                  sync1_q, sync1_d, sync2_q, sync2_d;
  logic                  hit_q, hit_d, stuck_q, stuck_d;
  chan_state_t           st_q, st_d;
  logic                  s, qual;
  logic [MINW_W_DEF-1:0] eff;
  logic [MINW_W_DEF:0]   wcnt_inc;

  always_comb begin
    sync1_d  = ~coax_raw;
    sync2_d  = sync1_q;
    s        = sync2_q;
    eff      = eff_width(min_width);
    wcnt_inc = {1'b0, st_q.wcnt} + (MINW_W_DEF+1)'(1);
    // Qualification with holdoff still running consumes the pulse without a hit.
    qual     = enable && s && st_q.armed && (wcnt_inc == {1'b0, eff});
    hit_d    = qual && (st_q.hcnt == '0);
    stuck_d  = enable && s && (st_q.stuck_cnt == STUCK_MAX);

    st_d = st_q;
    if (!enable || !s) begin
      st_d.wcnt      = '0;
      st_d.stuck_cnt = '0;
    end else begin
      if (st_q.wcnt != '1) st_d.wcnt = wcnt_inc[MINW_W_DEF-1:0];
      if (st_q.stuck_cnt != STUCK_MAX) st_d.stuck_cnt = st_q.stuck_cnt + STUCK_W_DEF'(1);
    end

    if (!s) st_d.armed = 1'b1;
    else if (qual) st_d.armed = 1'b0;

    if (hit_d) st_d.hcnt = holdoff;
    else if (st_q.hcnt != '0) st_d.hcnt = st_q.hcnt - HOLD_W_DEF'(1);
  end

  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hit_q   <= 1'b0;
      stuck_q <= 1'b0;
      st_q    <= '{wcnt: '0, armed: 1'b1, hcnt: '0, stuck_cnt: '0};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hit_q   <= hit_d;
      stuck_q <= stuck_d;
      st_q    <= st_d;
    end
  end

  assign hit   = hit_q;
  assign level = sync2_q;
  assign stuck = stuck_q;

endmodule

// File: rtl/coax_input_conditioner.sv
// Coax front end: NCH filtered channels plus gated hit-rate scalers with a snapshot bank.
module coax_input_conditioner
  import trig_in_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int MINW_W  = MINW_W_DEF,
  parameter int HOLD_W  = HOLD_W_DEF,
  parameter int SCAL_W  = SCAL_W_DEF,
  parameter int GATE_W  = GATE_W_DEF,
  parameter int STUCK_W = STUCK_W_DEF
) (
  input  logic              clk_adc,
  input  logic              nrst,
  input  logic [NCH-1:0]    coax_in,
  input  logic [NCH-1:0]    chan_mask,
  input  logic [MINW_W-1:0] min_width,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic              clear_rates,
  input  logic [3:0]        rate_sel,
  output logic [NCH-1:0]    hit_out,
  output logic [NCH-1:0]    level_out,
  output logic [SCAL_W-1:0] rate_out,
  output logic              rate_valid,
  output logic [NCH-1:0]    stuck_out
);

  function automatic logic [SCAL_W-1:0] sat_inc(input logic [SCAL_W-1:0] v);
    sat_inc = (v == '1) ? v : v + SCAL_W'(1);
  endfunction

  logic [NCH-1:0]    hit_w;
  logic [SCAL_W-1:0] live_q [NCH];
  logic [SCAL_W-1:0] live_d [NCH];
  logic [SCAL_W-1:0] snap_q [NCH];
  logic [SCAL_W-1:0] snap_d [NCH];
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [SCAL_W-1:0] rate_out_q, rate_out_d;
  logic              rate_valid_q, rate_valid_d;
  logic              wrap;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    coax_chan_filter #(.STUCK_W(STUCK_W)) u_filt (
      .clk_adc  (clk_adc),
      .nrst     (nrst),
      .coax_raw (coax_in[g]),
      .enable   (chan_mask[g]),
      .min_width(min_width),
      .holdoff  (holdoff),
      .hit      (hit_w[g]),
      .level    (level_out[g]),
      .stuck    (stuck_out[g])
    );
  end

  always_comb begin
    wrap         = &gate_q;
    gate_d       = gate_q + GATE_W'(1);
    rate_valid_d = wrap;
    rate_out_d   = snap_q[rate_sel];
    for (int c = 0; c < NCH; c++) begin
      live_d[c] = live_q[c];
      snap_d[c] = snap_q[c];
      if (clear_rates) begin
        live_d[c] = '0;
        snap_d[c] = '0;
      end else if (wrap) begin
        // A hit landing on the wrap cycle belongs to the new gate.
        snap_d[c] = live_q[c];
        live_d[c] = SCAL_W'(hit_w[c]);
      end else if (hit_w[c]) begin
        live_d[c] = sat_inc(live_q[c]);
      end
    end
    if (clear_rates) begin
      gate_d       = '0;
      rate_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      gate_q       <= '0;
      rate_out_q   <= '0;
      rate_valid_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        live_q[c] <= '0;
        snap_q[c] <= '0;
      end
    end else begin
      gate_q       <= gate_d;
      rate_out_q   <= rate_out_d;
      rate_valid_q <= rate_valid_d;
      for (int c = 0; c < NCH; c++) begin
        live_q[c] <= live_d[c];
        snap_q[c] <= snap_d[c];
      end
    end
  end

  assign hit_out    = hit_w;
  assign rate_out   = rate_out_q;
  assign rate_valid = rate_valid_q;

endmodule

// File: tb/tb_coax_input_conditioner.sv
// Directed bench for coax_input_conditioner with a short gate and short stuck threshold.
module tb_coax_input_conditioner;

  localparam int NCH     = 16;
  localparam int MINW_W  = 4;
  localparam int HOLD_W  = 8;
  localparam int SCAL_W  = 24;
  localparam int GATE_W  = 6;
  localparam int STUCK_W = 7;

  logic              clk_adc = 1'b0;
  logic              nrst;
  logic [NCH-1:0]    coax_in;
  logic [NCH-1:0]    chan_mask;
  logic [MINW_W-1:0] min_width;
  logic [HOLD_W-1:0] holdoff;
  logic              clear_rates;
  logic [3:0]        rate_sel;
  logic [NCH-1:0]    hit_out;
  logic [NCH-1:0]    level_out;
  logic [SCAL_W-1:0] rate_out;
  logic              rate_valid;
  logic [NCH-1:0]    stuck_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  coax_input_conditioner #(
    .NCH(NCH), .MINW_W(MINW_W), .HOLD_W(HOLD_W),
    .SCAL_W(SCAL_W), .GATE_W(GATE_W), .STUCK_W(STUCK_W)
  ) dut (
    .clk_adc    (clk_adc),
    .nrst       (nrst),
    .coax_in    (coax_in),
    .chan_mask  (chan_mask),
    .min_width  (min_width),
    .holdoff    (holdoff),
    .clear_rates(clear_rates),
    .rate_sel   (rate_sel),
    .hit_out    (hit_out),
    .level_out  (level_out),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .stuck_out  (stuck_out)
  );

  always #5 clk_adc = ~clk_adc;

  task automatic tick();
    @(posedge clk_adc);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    nrst = 1'b0; coax_in = '1; chan_mask = '1; min_width = 4'd1;
    holdoff = 8'd0; clear_rates = 1'b0; rate_sel = 4'd0;
    #2;
    total++; if (hit_out !== '0) begin bad++; $display("FAIL reset_hit got=%h want=0", hit_out); end
    total++; if (level_out !== '0) begin bad++; $display("FAIL reset_level got=%h want=0", level_out); end
    total++; if (stuck_out !== '0) begin bad++; $display("FAIL reset_stuck got=%h want=0", stuck_out); end
    total++; if (rate_out !== '0) begin bad++; $display("FAIL reset_rate got=%0d want=0", rate_out); end
    total++; if (rate_valid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", rate_valid); end
    repeat (3) tick();
    nrst = 1'b1;
    repeat (4) tick();
    total++; if (hit_out !== '0 || level_out !== '0) begin
      bad++; $display("FAIL idle_after_reset hit=%h level=%h want=0", hit_out, level_out);
    end
  endtask

  task automatic test_pulse_width();
    int hits;
    logic exp_hit;
    min_width = 4'd3;
    coax_in[0] = 1'b0; tick(); tick(); coax_in[0] = 1'b1;
    hits = 0;
    for (int t = 0; t < 8; t++) begin tick(); if (hit_out[0]) hits++; end
    total++; if (hits != 0) begin bad++; $display("FAIL short_pulse_hits got=%0d want=0", hits); end
    coax_in[0] = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 3) coax_in[0] = 1'b1;
      exp_hit = (t == 5);
      total++; if (hit_out[0] !== exp_hit) begin
        bad++; $display("FAIL width3_hit t=%0d got=%b want=%b", t, hit_out[0], exp_hit);
      end
    end
    min_width = 4'd0;
    coax_in[0] = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 1) coax_in[0] = 1'b1;
      exp_hit = (t == 3);
      total++; if (hit_out[0] !== exp_hit) begin
        bad++; $display("FAIL width0_hit t=%0d got=%b want=%b", t, hit_out[0], exp_hit);
      end
    end
    min_width = 4'd1;
  endtask

  task automatic test_long_pulse();
    int hits, first, stuck_seen;
    hits = 0; first = -1; stuck_seen = 0;
    holdoff = 8'd0; min_width = 4'd1;
    coax_in[5] = 1'b0;
    for (int t = 1; t <= 106; t++) begin
      tick();
      if (t == 100) coax_in[5] = 1'b1;
      if (hit_out[5]) begin hits++; if (first < 0) first = t; end
      if (stuck_out[5]) stuck_seen++;
    end
    total++; if (hits != 1) begin bad++; $display("FAIL long_hits got=%0d want=1", hits); end
    total++; if (first != 3) begin bad++; $display("FAIL long_latency got=%0d want=3", first); end
    total++; if (stuck_seen != 0) begin bad++; $display("FAIL long_stuck got=%0d want=0", stuck_seen); end
  endtask

  task automatic test_holdoff();
    logic exp_hit;
    holdoff = 8'd10; min_width = 4'd1;
    for (int t = 0; t < 25; t++) begin
      coax_in[2] = !(t == 0 || t == 5 || t == 13);
      tick();
      exp_hit = (t + 1 == 3) || (t + 1 == 16);
      total++; if (hit_out[2] !== exp_hit) begin
        bad++; $display("FAIL holdoff_hit t=%0d got=%b want=%b", t + 1, hit_out[2], exp_hit);
      end
    end
    coax_in[2] = 1'b1;
    holdoff = 8'd0;
    repeat (4) tick();
  endtask

  task automatic test_stuck();
    int hits;
    hits = 0;
    coax_in[6] = 1'b0;
    for (int t = 1; t <= 146; t++) begin
      tick();
      if (t == 140) coax_in[6] = 1'b1;
      if (hit_out[6]) hits++;
      if (t == 129 || t == 143) begin
        total++; if (stuck_out[6] !== 1'b0) begin
          bad++; $display("FAIL stuck_low t=%0d got=%b want=0", t, stuck_out[6]);
        end
      end
      if (t == 130 || t == 142) begin
        total++; if (stuck_out[6] !== 1'b1) begin
          bad++; $display("FAIL stuck_high t=%0d got=%b want=1", t, stuck_out[6]);
        end
      end
    end
    total++; if (hits != 1) begin bad++; $display("FAIL stuck_hits got=%0d want=1", hits); end
  endtask

  task automatic test_all_channels();
    coax_in = '0; tick(); coax_in = '1; tick(); tick();
    total++; if (hit_out !== '1) begin bad++; $display("FAIL all_hit got=%h want=ffff", hit_out); end
    tick();
    total++; if (hit_out !== '0) begin bad++; $display("FAIL all_hit_end got=%h want=0", hit_out); end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_pulse();
    logic exp_hit;
    coax_in[1] = 1'b0;
    repeat (5) tick();
    nrst = 1'b0;
    #1;
    total++; if (hit_out !== '0 || level_out !== '0 || stuck_out !== '0) begin
      bad++; $display("FAIL midreset_outs hit=%h level=%h stuck=%h want=0", hit_out, level_out, stuck_out);
    end
    total++; if (rate_valid !== 1'b0 || rate_out !== '0) begin
      bad++; $display("FAIL midreset_rate rv=%b rate=%0d want=0", rate_valid, rate_out);
    end
    tick(); tick();
    nrst = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_hit = (t == 3);
      total++; if (hit_out[1] !== exp_hit) begin
        bad++; $display("FAIL midreset_requal t=%0d got=%b want=%b", t, hit_out[1], exp_hit);
      end
    end
    coax_in[1] = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_mask();
    int c0, hits;
    chan_mask[7] = 1'b0; rate_sel = 4'd7; hits = 0;
    clear_rates = 1'b1; tick(); clear_rates = 1'b0; c0 = cyc;
    coax_in[7] = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 3) coax_in[7] = 1'b1;
      if (hit_out[7]) hits++;
      if (t == 1 || t == 5) begin
        total++; if (level_out[7] !== 1'b0) begin bad++; $display("FAIL mask_level t=%0d got=%b want=0", t, level_out[7]); end
      end
      if (t == 2) begin
        total++; if (level_out[7] !== 1'b1) begin bad++; $display("FAIL mask_level t=%0d got=%b want=1", t, level_out[7]); end
      end
    end
    total++; if (hits != 0) begin bad++; $display("FAIL mask_hits got=%0d want=0", hits); end
    while (cyc - c0 < 64) tick();
    total++; if (rate_valid !== 1'b1) begin bad++; $display("FAIL mask_rvalid got=%b want=1", rate_valid); end
    tick();
    total++; if (rate_out !== 24'd0) begin bad++; $display("FAIL mask_rate got=%0d want=0", rate_out); end
    chan_mask = '1;
  endtask

  task automatic test_scaler();
    int c0, hits;
    min_width = 4'd1; holdoff = 8'd0; rate_sel = 4'd3; hits = 0;
    clear_rates = 1'b1; tick(); clear_rates = 1'b0; c0 = cyc;
    for (int p = 0; p < 5; p++) begin
      coax_in[3] = 1'b0; tick(); if (hit_out[3]) hits++;
      coax_in[3] = 1'b1;
      repeat (3) begin tick(); if (hit_out[3]) hits++; end
    end
    total++; if (hits != 5) begin bad++; $display("FAIL scaler_hits got=%0d want=5", hits); end
    while (cyc - c0 < 60) tick();
    coax_in[3] = 1'b0; tick(); coax_in[3] = 1'b1; tick(); tick();
    total++; if (hit_out[3] !== 1'b1 || rate_valid !== 1'b0) begin
      bad++; $display("FAIL wrap_cycle hit=%b rv=%b want hit=1 rv=0", hit_out[3], rate_valid);
    end
    tick();
    total++; if (rate_valid !== 1'b1) begin bad++; $display("FAIL scaler_rvalid got=%b want=1", rate_valid); end
    tick();
    total++; if (rate_out !== 24'd5) begin bad++; $display("FAIL scaler_rate got=%0d want=5", rate_out); end
    total++; if (rate_valid !== 1'b0) begin bad++; $display("FAIL scaler_rvalid_len got=%b want=0", rate_valid); end
    while (cyc - c0 < 128) tick();
    total++; if (rate_valid !== 1'b1) begin bad++; $display("FAIL gate2_rvalid got=%b want=1", rate_valid); end
    tick();
    total++; if (rate_out !== 24'd1) begin bad++; $display("FAIL gate2_rate got=%0d want=1", rate_out); end
  endtask

  task automatic test_clear();
    int c0;
    rate_sel = 4'd3;
    clear_rates = 1'b1; tick(); clear_rates = 1'b0; c0 = cyc;
    for (int p = 0; p < 2; p++) begin
      coax_in[3] = 1'b0; tick(); coax_in[3] = 1'b1; repeat (3) tick();
    end
    while (cyc - c0 < 64) tick();
    total++; if (rate_valid !== 1'b1) begin bad++; $display("FAIL clear_pre_rvalid got=%b want=1", rate_valid); end
    tick();
    total++; if (rate_out !== 24'd2) begin bad++; $display("FAIL clear_pre_rate got=%0d want=2", rate_out); end
    for (int p = 0; p < 3; p++) begin
      coax_in[4] = 1'b0; tick(); coax_in[4] = 1'b1; repeat (3) tick();
    end
    while (cyc - c0 < 127) tick();
    clear_rates = 1'b1; tick(); clear_rates = 1'b0;
    total++; if (rate_valid !== 1'b0) begin bad++; $display("FAIL clear_rvalid got=%b want=0", rate_valid); end
    for (int c = 0; c < NCH; c++) begin
      rate_sel = 4'(c);
      tick();
      total++; if (rate_out !== 24'd0) begin bad++; $display("FAIL clear_rate ch=%0d got=%0d want=0", c, rate_out); end
    end
    rate_sel = 4'd4;
    while (cyc - c0 < 192) tick();
    total++; if (rate_valid !== 1'b1) begin bad++; $display("FAIL clear_next_rvalid got=%b want=1", rate_valid); end
    tick();
    total++; if (rate_out !== 24'd0) begin bad++; $display("FAIL clear_live_rate got=%0d want=0", rate_out); end
  endtask

  initial begin
    test_reset();
    test_pulse_width();
    test_long_pulse();
    test_holdoff();
    test_stuck();
    test_all_channels();
    test_reset_mid_pulse();
    test_mask();
    test_scaler();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coax_input_conditioner.md
Name: coax_input_conditioner

Overview:
- Front-end stage for the trigger board's coax inputs: synchronises and inverts raw active-low coax_in, rejects glitches shorter than a programmable width, and emits one clean single-cycle hit per qualified pulse.
- Sits directly upstream of the coincidence/trigger stage, which consumes hit_out in place of raw inputs.
- Also provides per-channel hit-rate scalers over a fixed gate and stuck-input flags for monitoring readout.

Parameters:
NCH, 16, number of coax channels
MINW_W, 4, width of min_width
HOLD_W, 8, width of holdoff
SCAL_W, 24, rate scaler width
GATE_W, 26, gate length is 2^GATE_W clk_adc cycles
STUCK_W, 16, a channel is stuck after 2^STUCK_W consecutive high samples

Ports:
clk_adc  in  1  sole clock
nrst  in  1  reset, asynchronous, active-low
coax_in  in  NCH  raw inputs, active-low (unconnected = 1 = idle)
chan_mask  in  NCH  1 = channel enabled
min_width  in  MINW_W  required consecutive high samples; 0 treated as 1
holdoff  in  HOLD_W  dead cycles after each hit, per channel
clear_rates  in  1  synchronous clear of scalers, snapshots and gate counter
rate_sel  in  4  channel select for rate_out
hit_out  out  NCH  one-cycle pulse per qualified pulse
level_out  out  NCH  synchronised, inverted level (s)
rate_out  out  SCAL_W  snapshot of selected channel
rate_valid  out  1  one-cycle pulse when a new snapshot bank is taken
stuck_out  out  NCH  channel held high too long

Behaviour:
- Reset: all outputs 0. Sync flops, width counters, holdoff counters, stuck counters, scalers, snapshots and gate counter are 0. All channels armed.
- Sync: two flops per channel capture ~coax_in. s is the second flop output. level_out = s.
- Width counter wcnt:
  - Increments while s=1, saturating at 2^MINW_W-1; cleared when s=0.
  - eff = max(min_width,1).
  - A pulse qualifies in the cycle where s=1 and wcnt+1 == eff.
  - hit_out is registered, so a raw low first sampled at edge k gives hit_out high after edge k+1+eff, for exactly one cycle.
- Armed flag:
  - Cleared on qualification; set again when s=0.
  - Guarantees at most one hit per pulse regardless of pulse length.
- Holdoff:
  - On each hit, hcnt is loaded with holdoff and decrements to 0.
  - A pulse qualifying while hcnt>0 is discarded: no hit, armed cleared, no deferred hit.
  - holdoff=0 means no dead time.
- chan_mask=0: hit_out forced 0, wcnt held 0, scaler not incremented, stuck flag cleared. level_out is still driven.
- Scalers:
  - Per-channel live count increments on each hit, saturating at 2^SCAL_W-1.
  - The gate counter free-runs. At all-ones it wraps and, in the same cycle:
    - copies all live counts to the snapshot bank;
    - resets live counts (to 1 if that channel hits in the same cycle, else 0);
    - pulses rate_valid.
- rate_out = snapshot[rate_sel], registered, 1-cycle latency.
- clear_rates zeroes live counts, snapshots and the gate counter, and takes priority over a coincident gate wrap (no rate_valid). It does not affect hit_out, wcnt, armed or hcnt.
- Stuck detection:
  - Per-channel counter counts consecutive s=1 cycles, saturating.
  - stuck_out is set at 2^STUCK_W consecutive high samples and cleared the cycle after s=0.
  - A stuck channel still produces its single hit; hits are not suppressed.
- Channels are fully independent; simultaneous hits on all NCH channels are legal and all counted.
- nrst asserted mid-pulse: state is cleared immediately. After release, a pulse still held high re-qualifies as a new pulse once eff samples have been seen.

Decomposition:
- Shared package trig_in_pkg: NCH and the default widths, plus a chan_state_t struct {wcnt, armed, hcnt, stuck_cnt}.
- One sub-module, coax_chan_filter:
  - contains sync, width, armed, holdoff and stuck logic for a single channel, with hit and level outputs;
  - instantiated NCH times by generate.
- Scalers, gate counter, snapshot bank and rate_out mux stay in the top.

Test Plan:
- Pulse width, min_width=3: drive coax_in[0] low for 2 cycles -> no hit. Drive low for 3 cycles -> hit_out[0] high exactly one cycle, 4 edges after the first low is sampled.
- Long pulse, min_width=1, holdoff=0: coax_in[5] low for 100 cycles -> exactly one hit_out[5] pulse, 2 edges after the first low. stuck_out[5] stays 0.
- Holdoff, holdoff=10: pulses on ch2 qualifying 5 cycles apart -> second pulse dropped. A third pulse qualifying 12 cycles after the first hit -> hit.
- Mask: chan_mask[7]=0 with pulses on ch7 -> hit_out[7]=0 and snapshot for ch7 = 0. level_out[7] still follows the input.
- Scaler (GATE_W reduced to 6 in bench): 5 hits on ch3 within one gate -> rate_valid pulses at the wrap; rate_sel=3 gives rate_out=5 one cycle later. A hit on ch3 in the wrap cycle appears as 1 in the next gate.
- Reset and clear: assert nrst mid-pulse -> all outputs 0 immediately. Assert clear_rates on the wrap cycle -> no rate_valid, and rate_out=0 for every channel.
